stn_fpgen: RTL and testbench

STN panel timing generator: the transmit side of the 4-bit monochrome STN interface (FPFRAME/FPLINE/FPSHIFT/FPDAT[3:0]) that the STN-to-TFT logic receives. It pulls 4-pixel nibbles from an upstream frame-buffer reader through a valid/ready slot handshake. It produces continuous panel frames with a programmable shift-clock divider, line blanking and frame pulse. Used as a bench/bring-up source for the converter and as the panel driver in STN-output builds.

---
 rtl/stn_fpgen.sv | 157 +++++++++++++++
 tb/tb_stn_fpgen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stn_fpgen.sv
// stn_fpgen: 4-bit monochrome STN panel timing generator.
// Pulls one nibble per shift period from an upstream reader through a
// slot handshake (din_rdy strobe, din_vld qualifier) and drives
// FPSHIFT/FPLINE/FPFRAME/FPDAT[3:0] with frame blank, line blank and
// active periods. All panel outputs are registered; only din_rdy is
// combinational so the reader sees the slot in the same cycle.
module stn_fpgen #(
  parameter int H_PIX     = 320,
  parameter int V_LINES   = 240,
  parameter int HB        = 8,
  parameter int LP_W      = 2,
  parameter int SHIFT_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic       frame_start,
  output logic       underrun,
  output logic       stn_fpshift,
  output logic       stn_fpline,
  output logic       stn_fpframe,
  output logic [3:0] stn_fpdat
);

  // Shift periods per active line.
  localparam int H_NIB = H_PIX / 4;
  // hcnt counts both active and blank periods, so size it for the larger.
  localparam int H_MAX = (H_NIB > HB) ? H_NIB : HB;

  localparam int PW = $clog2(SHIFT_DIV);
  localparam int HW = $clog2(H_MAX);
  localparam int VW = $clog2(V_LINES);

  localparam logic [PW-1:0] PH_LAST  = PW'(SHIFT_DIV - 1);
  // FPSHIFT rises on the edge leaving ph=0 and falls on the edge leaving
  // this phase, giving SHIFT_DIV/2 clocks high and SHIFT_DIV/2 clocks low.
  localparam logic [PW-1:0] PH_FALL  = PW'(SHIFT_DIV / 2);
  localparam logic [HW-1:0] NIB_LAST = HW'(H_NIB - 1);
  localparam logic [HW-1:0] BLK_LAST = HW'(HB - 1);
  localparam logic [HW-1:0] LP_HI    = HW'(LP_W);
  localparam logic [VW-1:0] V_LAST   = VW'(V_LINES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FBLK = 2'd1,
    ACT  = 2'd2,
    LBLK = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] ph;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  logic          ph_wrap;
  logic [HW-1:0] hcnt_inc;
  logic [PW-1:0] ph_inc;

  assign ph_wrap  = (ph == PH_LAST);
  assign ph_inc   = ph_wrap ? '0 : ph + PW'(1);
  assign hcnt_inc = hcnt + HW'(1);

  // Slot strobe: first phase of every active shift period.
  assign din_rdy = (state == ACT) && (ph == '0);

  // Timing FSM with counters and registered panel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ph          <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      stn_fpshift <= 1'b0;
      stn_fpline  <= 1'b0;
      stn_fpframe <= 1'b0;
      stn_fpdat   <= 4'h0;
    end else begin
      frame_start <= 1'b0;
      unique case (state)
        IDLE: begin
          ph   <= '0;
          hcnt <= '0;
          vcnt <= '0;
          if (en) begin
            state       <= FBLK;
            stn_fpframe <= 1'b1;
            frame_start <= 1'b1;
          end
        end

        FBLK, LBLK: begin
          ph <= ph_inc;
          if (ph_wrap) begin
            if (hcnt == BLK_LAST) begin
              state       <= ACT;
              hcnt        <= '0;
              stn_fpline  <= 1'b0;
              stn_fpframe <= 1'b0;
              if (state == FBLK) begin
                vcnt <= '0;
              end else begin
                vcnt <= vcnt + VW'(1);
              end
            end else begin
              hcnt <= hcnt_inc;
              // hcnt_inc is never 0 here, so only the upper bound matters.
              stn_fpline <= (hcnt_inc <= LP_HI);
            end
          end
        end

        ACT: begin
          ph <= ph_inc;
          if (ph == '0) begin
            // Slot: take the nibble, or blank it and flag an underrun.
            stn_fpdat   <= din_vld ? din : 4'h0;
            stn_fpshift <= 1'b1;
            if (!din_vld) begin
              underrun <= 1'b1;
            end
          end else if (ph == PH_FALL) begin
            stn_fpshift <= 1'b0;
          end
          if (ph_wrap) begin
            if (hcnt == NIB_LAST) begin
              hcnt      <= '0;
              stn_fpdat <= 4'h0;
              if (vcnt != V_LAST) begin
                state <= LBLK;
              end else begin
                // Last line: en at this clock decides next frame vs. stop.
                vcnt <= '0;
                if (en) begin
                  state       <= FBLK;
                  stn_fpframe <= 1'b1;
                  frame_start <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              hcnt <= hcnt_inc;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stn_fpgen.sv
// tb_stn_fpgen: directed bench for stn_fpgen. One instance uses the
// common small geometry (16 px, 3 lines, SHIFT_DIV=4); a second instance
// uses SHIFT_DIV=2 / 8 px. A cycle log is checked against a table of
// hand-computed vectors plus counted windows; per-cycle checks cover
// data order, shift-clock shape and the sticky underrun flag.
module tb_stn_fpgen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] din = 4'h0;
  logic       din_vld = 1'b0;
  logic       din_rdy, frame_start, underrun, fpshift, fpline, fpframe;
  logic [3:0] fpdat;

  logic [3:0] din2 = 4'h5;
  logic       din_vld2 = 1'b1;
  logic       din_rdy2, frame_start2, underrun2, fpshift2, fpline2, fpframe2;
  logic [3:0] fpdat2;

  always #5 clk = ~clk;

  stn_fpgen #(.H_PIX(16), .V_LINES(3), .HB(4), .LP_W(2), .SHIFT_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_vld(din_vld),
    .din_rdy(din_rdy), .frame_start(frame_start), .underrun(underrun),
    .stn_fpshift(fpshift), .stn_fpline(fpline), .stn_fpframe(fpframe),
    .stn_fpdat(fpdat)
  );

  stn_fpgen #(.H_PIX(8), .V_LINES(3), .HB(4), .LP_W(2), .SHIFT_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din2), .din_vld(din_vld2),
    .din_rdy(din_rdy2), .frame_start(frame_start2), .underrun(underrun2),
    .stn_fpshift(fpshift2), .stn_fpline(fpline2), .stn_fpframe(fpframe2),
    .stn_fpdat(fpdat2)
  );

  localparam int DROP_SLOT = 18;  // frame 2, line 1, slot 2 (0-based)
  localparam int LOGN = 400;

  typedef struct packed {
    int         cyc;
    logic       fr;
    logic       ln;
    logic       sh;
    logic       rdy;
    logic       fs;
    logic       un;
    logic [3:0] dat;
  } vec_t;

  vec_t vecs [0:27];

  int         cyc = -3;
  int         pass_cnt = 0;
  int         chk_cnt = 0;
  int         slot_idx = 0;
  int         nib = 0;
  logic       pend = 1'b0;
  logic [3:0] pend_val = 4'h0;
  logic       rdy_p1 = 1'b0, rdy_p2 = 1'b0, rdy2_p1 = 1'b0;
  logic       exp_under = 1'b0, exp_under_nxt = 1'b0;
  logic [9:0] log1 [0:LOGN-1];
  logic [2:0] log2 [0:LOGN-1];

  task automatic chk(input string name, input int act, input int req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  // Count set bits of log1 field b over cycles a..z inclusive.
  function automatic int cnt1(input int b, input int a, input int z);
    int n = 0;
    for (int c = a; c <= z; c++) if (log1[c][b]) n++;
    return n;
  endfunction

  function automatic int cnt2(input int b, input int a, input int z);
    int n = 0;
    for (int c = a; c <= z; c++) if (log2[c][b]) n++;
    return n;
  endfunction

  // One clock: check and log this cycle's outputs, then drive inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    exp_under = rst ? 1'b0 : exp_under_nxt;
    if (pend) chk($sformatf("fpdat@%0d", cyc), int'(fpdat), int'(pend_val));
    chk($sformatf("fpshift@%0d", cyc), int'(fpshift), int'(!rst && (rdy_p1 || rdy_p2)));
    chk($sformatf("underrun@%0d", cyc), int'(underrun), int'(exp_under));
    chk($sformatf("fpshift2@%0d", cyc), int'(fpshift2), int'(!rst && rdy2_p1));
    if (cyc >= 0 && cyc < LOGN) begin
      log1[cyc] = {fpframe, fpline, fpshift, din_rdy, frame_start, underrun, fpdat};
      log2[cyc] = {fpline2, fpshift2, din_rdy2};
    end
    rdy_p2  = rst ? 1'b0 : rdy_p1;
    rdy_p1  = rst ? 1'b0 : din_rdy;
    rdy2_p1 = rst ? 1'b0 : din_rdy2;
    if (rst) exp_under_nxt = 1'b0;

    en   = (cyc >= 0 && cyc < 245) || (cyc >= 330);
    pend = 1'b0;
    if (din_rdy) begin
      din_vld  = (slot_idx != DROP_SLOT);
      din      = din_vld ? 4'(nib) : 4'hF;
      pend     = 1'b1;
      pend_val = din_vld ? 4'(nib) : 4'h0;
      if (din_vld) nib++;
      else exp_under_nxt = 1'b1;
      slot_idx++;
    end else if (cyc >= 97) begin
      din_vld = 1'($urandom);
      din     = 4'($urandom);
    end else begin
      din_vld = 1'b1;
      din     = 4'(nib);
    end
  endtask

  initial begin
    //            cyc  fr    ln    sh    rdy   fs    un    dat
    vecs[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[2]  = '{2,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{5,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[4]  = '{12,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[5]  = '{13,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[6]  = '{17,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[7]  = '{18,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[8]  = '{20,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[9]  = '{22,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
    vecs[10] = '{30,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3};
    vecs[11] = '{32,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3};
    vecs[12] = '{33,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[13] = '{37,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[14] = '{50,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4};
    vecs[15] = '{97,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[16] = '{150, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
    vecs[17] = '{153, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1};
    vecs[18] = '{154, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0};
    vecs[19] = '{158, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2};
    vecs[20] = '{246, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hC};
    vecs[21] = '{289, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
    vecs[22] = '{330, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
    vecs[23] = '{331, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vecs[24] = '{352, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4};
    vecs[25] = '{354, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[26] = '{356, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[27] = '{357, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};

    // Reset state.
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({fpframe, fpline, fpshift, din_rdy, frame_start, underrun, fpdat}), 0);
    chk("reset_outputs2", int'({fpframe2, fpline2, fpshift2, din_rdy2, frame_start2, underrun2, fpdat2}), 0);
    rst = 1'b0;

    // Three frames, en drop during frame 3 line 1, re-enable at 330.
    while (cyc < 352) step();

    // Asynchronous reset mid-ACT: outputs clear without a clock edge.
    rst = 1'b1;
    #1;
    chk("rst_async_fpshift", int'(fpshift), 0);
    chk("rst_async_fpdat", int'(fpdat), 0);
    chk("rst_async_underrun", int'(underrun), 0);
    chk("rst_async_din_rdy", int'(din_rdy), 0);
    chk("rst_async_other", int'({fpframe, fpline, frame_start}), 0);
    repeat (3) step();
    chk("rst_hold_outputs", int'({fpframe, fpline, fpshift, din_rdy, frame_start, underrun, fpdat}), 0);
    rst = 1'b0;
    while (cyc < LOGN - 1) step();

    // Table-driven vector checks against the log.
    for (int i = 0; i < 28; i++) begin
      chk($sformatf("vec%0d@%0d {fr,ln,sh,rdy,fs,un,dat}", i, vecs[i].cyc),
          int'(log1[vecs[i].cyc]),
          int'({vecs[i].fr, vecs[i].ln, vecs[i].sh, vecs[i].rdy, vecs[i].fs, vecs[i].un, vecs[i].dat}));
    end

    // Windowed counts (bits: 9 fr, 8 ln, 7 sh, 6 rdy, 5 fs).
    chk("rdy_per_line0", cnt1(6, 17, 32), 4);
    chk("rdy_frame1", cnt1(6, 1, 96), 12);
    chk("rdy_frame2_with_underrun", cnt1(6, 97, 192), 12);
    chk("fpline_one_line", cnt1(8, 33, 64), 8);
    chk("fpline_frame1", cnt1(8, 1, 96), 24);
    chk("fpframe_frame1", cnt1(9, 1, 96), 16);
    chk("frame_start_2frames", cnt1(5, 1, 192), 2);
    chk("fpshift_act0", cnt1(7, 17, 32), 8);
    chk("en_drop_no_fpframe", cnt1(9, 289, 329), 0);
    chk("en_drop_no_fpline", cnt1(8, 273, 329), 0);
    chk("en_drop_no_rdy", cnt1(6, 289, 329), 0);
    chk("frame_start_frame3", cnt1(5, 193, 330), 1);
    chk("frame_start_after_rst", cnt1(5, 353, 375), 1);

    // SHIFT_DIV=2 instance (bits: 2 ln, 1 sh, 0 rdy).
    chk("d2_rdy_c9", int'(log2[9][0]), 1);
    chk("d2_rdy_c21", int'(log2[21][0]), 1);
    chk("d2_rdy_count", cnt2(0, 1, 24), 4);
    chk("d2_fpline_width", cnt2(2, 13, 24), 4);
    chk("d2_fpline_rise_c3", int'({log2[2][2], log2[3][2]}), 1);
    chk("d2_fpline_rise_c15", int'({log2[14][2], log2[15][2]}), 1);
    chk("d2_fpshift_count", cnt2(1, 9, 20), 2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
